// File: rtl/result_collector.sv
// Drain-side deserializer: packs a stream of WIDTH-bit lane values into one
// LANES*WIDTH word, first byte in the top lane, with a one-deep output buffer.
module result_collector #(
    parameter int LANES = 7,
    parameter int WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic signed [WIDTH-1:0]       in_data,
    output logic                          in_ready,
    input  logic                          flush,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES*WIDTH-1:0]        out_data,
    output logic [$clog2(LANES+1)-1:0]    out_count,
    output logic                          out_partial
);

    localparam int DW = LANES * WIDTH;
    localparam int CW = $clog2(LANES + 1);

    typedef enum logic {COLLECT, HOLD} state_t;

    state_t          state, state_nxt;
    logic [DW-1:0]   asm_reg, asm_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [CW-1:0]   hold_cnt, hold_cnt_nxt;
    logic [DW-1:0]   odata_nxt;
    logic [CW-1:0]   ocnt_nxt;
    logic            opart_nxt, ovalid_nxt;

    logic            accept, oreg_free, close;
    logic [DW-1:0]   shifted, closed;
    logic [CW-1:0]   n;

    assign in_ready = (state == COLLECT);

    always_comb begin
        accept    = in_valid && in_ready;
        oreg_free = !out_valid || out_ready;
        shifted   = accept ? {asm_reg[DW-WIDTH-1:0], in_data} : asm_reg;
        n         = accept ? cnt + CW'(1) : cnt;
        close     = (state == COLLECT) &&
                    ((accept && n == CW'(LANES)) || (flush && n != '0));
        // Left-align a flushed word so its first byte still sits in the top lane.
        closed    = shifted << (WIDTH * (LANES - int'(n)));

        state_nxt    = state;
        asm_nxt      = asm_reg;
        cnt_nxt      = cnt;
        hold_cnt_nxt = hold_cnt;
        odata_nxt    = out_data;
        ocnt_nxt     = out_count;
        opart_nxt    = out_partial;
        ovalid_nxt   = out_valid && !out_ready;

        case (state)
            COLLECT: begin
                if (close) begin
                    cnt_nxt = '0;
                    if (oreg_free) begin
                        odata_nxt  = closed;
                        ocnt_nxt   = n;
                        opart_nxt  = (n != CW'(LANES));
                        ovalid_nxt = 1'b1;
                        asm_nxt    = '0;
                    end else begin
                        // asm keeps the aligned word and its lane count while parked.
                        asm_nxt      = closed;
                        hold_cnt_nxt = n;
                        state_nxt    = HOLD;
                    end
                end else begin
                    asm_nxt = shifted;
                    cnt_nxt = n;
                end
            end
            HOLD: begin
                if (oreg_free) begin
                    odata_nxt  = asm_reg;
                    ocnt_nxt   = hold_cnt;
                    opart_nxt  = (hold_cnt != CW'(LANES));
                    ovalid_nxt = 1'b1;
                    asm_nxt    = '0;
                    state_nxt  = COLLECT;
                end
            end
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= COLLECT;
            asm_reg     <= '0;
            cnt         <= '0;
            hold_cnt    <= '0;
            out_data    <= '0;
            out_count   <= '0;
            out_partial <= 1'b0;
            out_valid   <= 1'b0;
        end else begin
            state       <= state_nxt;
            asm_reg     <= asm_nxt;
            cnt         <= cnt_nxt;
            hold_cnt    <= hold_cnt_nxt;
            out_data    <= odata_nxt;
            out_count   <= ocnt_nxt;
            out_partial <= opart_nxt;
            out_valid   <= ovalid_nxt;
        end
    end

endmodule

// File: tb/tb_result_collector.sv
// Self-checking bench for result_collector: table-driven words plus
// hand-written backpressure, flush and reset sequences, scoreboard-checked.
module tb_result_collector;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic signed [7:0] in_data;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [55:0] out_data;
    logic [2:0]  out_count;
    logic        out_partial;

    int unsigned errors = 0;
    int unsigned checks = 0;

    typedef struct {
        logic [55:0] data;
        logic [2:0]  count;
        logic        partial;
    } word_t;

    word_t sb[$];

    typedef struct {
        int          nbytes;
        logic [55:0] bytes;      // top byte sent first
        bit          flush_last;
        logic [55:0] exp_data;
        logic [2:0]  exp_count;
        logic        exp_partial;
    } vec_t;

    result_collector #(.LANES(7), .WIDTH(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_count(out_count),
        .out_partial(out_partial)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Output monitor: a word present with out_ready high is taken at the next edge.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", {8'h0, out_data}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                word_t w;
                w = sb.pop_front();
                chk("out_data", {8'h0, out_data}, {8'h0, w.data});
                chk("out_count", {61'h0, out_count}, {61'h0, w.count});
                chk("out_partial", {63'h0, out_partial}, {63'h0, w.partial});
            end
        end
    end

    task automatic send(input logic [7:0] b, input bit fl);
        int unsigned t = 0;
        in_valid = 1'b1;
        in_data  = b;
        flush    = fl;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic drain();
        int unsigned t = 0;
        while (sb.size() != 0 && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{7, 56'h01020304050607, 1'b0, 56'h01020304050607, 3'd7, 1'b0};
        vecs[1] = '{7, 56'h80FF7F0001FE55, 1'b0, 56'h80FF7F0001FE55, 3'd7, 1'b0};
        vecs[2] = '{4, 56'hAABBCCDD000000, 1'b1, 56'hAABBCCDD000000, 3'd4, 1'b1};
        vecs[3] = '{7, 56'h31323334353637, 1'b1, 56'h31323334353637, 3'd7, 1'b0};
        vecs[4] = '{1, 56'h5A000000000000, 1'b1, 56'h5A000000000000, 3'd1, 1'b1};

        reset = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {63'h0, out_valid}, 64'd0);
        chk("rst_out_data", {8'h0, out_data}, 64'd0);
        chk("rst_in_ready", {63'h0, in_ready}, 64'd1);
        reset = 1'b0;
        cycle();

        // Table-driven words with out_ready held high.
        out_ready = 1'b1;
        foreach (vecs[v]) begin
            sb.push_back('{vecs[v].exp_data, vecs[v].exp_count, vecs[v].exp_partial});
            for (int i = 0; i < vecs[v].nbytes; i++) begin
                logic [7:0] b;
                b = vecs[v].bytes[55 - 8*i -: 8];
                chk("in_ready_collect", {63'h0, in_ready}, 64'd1);
                send(b, vecs[v].flush_last && (i == vecs[v].nbytes - 1));
            end
            chk("latency_valid", {63'h0, out_valid}, 64'd1);
            drain();
        end

        // Backpressure: two words, second parked in HOLD.
        out_ready = 1'b0;
        for (int i = 0; i < 14; i++) send(8'h10 + 8'(i), 1'b0);
        chk("hold_in_ready", {63'h0, in_ready}, 64'd0);
        chk("hold_out_valid", {63'h0, out_valid}, 64'd1);
        chk("hold_word1", {8'h0, out_data}, {8'h0, 56'h10111213141516});
        repeat (3) cycle();
        chk("hold_word1_stable", {8'h0, out_data}, {8'h0, 56'h10111213141516});
        chk("hold_still_stalled", {63'h0, in_ready}, 64'd0);
        sb.push_back('{56'h10111213141516, 3'd7, 1'b0});
        sb.push_back('{56'h1718191A1B1C1D, 3'd7, 1'b0});
        out_ready = 1'b1;
        cycle();
        chk("release_in_ready", {63'h0, in_ready}, 64'd1);
        chk("release_word2_valid", {63'h0, out_valid}, 64'd1);
        drain();

        // Flush of a partial word, then a flush with nothing collected.
        send(8'hAA, 1'b0); send(8'hBB, 1'b0); send(8'hCC, 1'b0);
        sb.push_back('{56'hAABBCC00000000, 3'd3, 1'b1});
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("flush_valid", {63'h0, out_valid}, 64'd1);
        drain();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("empty_flush_ignored", {63'h0, out_valid}, 64'd0);
        repeat (2) cycle();
        chk("empty_flush_quiet", {63'h0, out_valid}, 64'd0);

        // Reset mid-word with the output register occupied.
        out_ready = 1'b0;
        for (int i = 0; i < 11; i++) send(8'h60 + 8'(i), 1'b0);
        chk("pre_reset_valid", {63'h0, out_valid}, 64'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_out_valid", {63'h0, out_valid}, 64'd0);
        chk("mid_rst_out_data", {8'h0, out_data}, 64'd0);
        chk("mid_rst_out_count", {61'h0, out_count}, 64'd0);
        chk("mid_rst_out_partial", {63'h0, out_partial}, 64'd0);
        chk("mid_rst_in_ready", {63'h0, in_ready}, 64'd1);
        cycle();
        reset = 1'b0;
        cycle();
        out_ready = 1'b1;
        sb.push_back('{56'h21222324252627, 3'd7, 1'b0});
        for (int i = 0; i < 7; i++) send(8'h21 + 8'(i), 1'b0);
        drain();
        repeat (2) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/result_collector.md
Name: result_collector

Overview:
- Deserializer on the drain side of the systolic MAC array: packs a stream of signed 8-bit lane values into one 56-bit word (7 × 8 bits).
- Its packing order is the inverse of the 56-bit→8-bit feeder's. The first byte received lands in bits [55:48], so a word serialized MSB-byte-first is reconstructed bit-exact.
- Sits between the array output edge and the result writeback path.
- Valid/ready on both sides; one-deep output buffer so collection continues while a finished word waits.
- Flush emits a zero-padded partial word at end of stream.

Parameters:
- LANES, 7, bytes per packed word.
- WIDTH, 8, bits per lane; out_data width = LANES*WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_data valid this cycle.
- in_data  in  WIDTH (signed)  lane value.
- in_ready  out  1  collector can accept in_data this cycle.
- flush  in  1  close the current partial word.
- out_valid  out  1  out_data/out_count/out_partial valid.
- out_ready  in  1  downstream accepts the output word.
- out_data  out  LANES*WIDTH  packed word, first byte in the top lane.
- out_count  out  $clog2(LANES+1)  number of real lanes in out_data (1..LANES).
- out_partial  out  1  word was closed by flush (out_count < LANES).

Behaviour:
- Interface: clock clk; reset reset, asynchronous, active-high.
- Storage: assembly register asm (LANES*WIDTH) plus lane counter cnt (0..LANES-1); output register oreg with count, partial flag, and valid bit.
- Accept: accept = in_valid && in_ready. On accept, asm <= {asm[LANES*WIDTH-WIDTH-1:0], in_data} and cnt increments. Data bits pass through unmodified; no sign extension.
- States:
  - COLLECT: asm has 0..LANES-1 bytes. in_ready=1.
  - HOLD: asm complete or flushed, waiting for oreg to free. in_ready=0.
- Close: a word closes on the accept that brings the lane count to LANES, or on flush with at least 1 lane.
  - A flush-closed word is left-aligned: it is shifted left by WIDTH*(LANES-n) with zero fill, out_count=n, out_partial=1.
  - A full word has out_count=LANES and out_partial=0.
- Transfer: a closed word moves to oreg on the same edge if oreg is empty or is being popped that edge (out_valid && out_ready). Otherwise the state goes to HOLD. asm and cnt clear on transfer.
- In HOLD, transfer happens on the first edge where oreg is empty or popped; the state then returns to COLLECT.
- Latency: last byte accepted at edge N → out_valid=1 from edge N (visible in cycle N+1). Sustained throughput is 1 byte/clk with out_ready held high.
- Output: out_valid stays high and out_data/out_count/out_partial stay stable until out_ready=1. Pop and refill in the same edge are allowed with no bubble.
- Flush:
  - Flush and accept in the same cycle: the byte is included, then the word closes. If that byte completes the word, it is a normal full word with out_partial=0.
  - Flush with cnt=0 and no accept: ignored.
  - Flush in HOLD: ignored.
  - Flush is a level, sampled each cycle.
- Reset (any time, including mid-word or with oreg full):
  - asm=0, cnt=0, state=COLLECT, oreg cleared.
  - out_valid=0, out_data=0, out_count=0, out_partial=0.
  - in_ready=1 once the state is COLLECT. A partial word is discarded and is not emitted.
- in_ready is combinational from state only; it has no dependence on in_valid.

Test Plan:
1. Bytes 01,02,…,07 on consecutive cycles with out_ready=1 → one cycle after the 7th accept: out_valid=1, out_data=56'h01020304050607, out_count=7, out_partial=0. in_ready stays 1 throughout.
2. Round trip: serialize 56'h80FF7F0001FE55 top byte first and feed it in → out_data is 56'h80FF7F0001FE55 exactly, confirming signed bytes pass unchanged.
3. out_ready=0, stream 14 bytes 10..1D →
   - word1 = 56'h10111213141516 held stable in oreg;
   - word2 = 56'h1718191A1B1C1D held in HOLD, in_ready=0 from the 14th accept;
   - raise out_ready → word1 pops, word2 is valid the next cycle, in_ready returns to 1.
4. Bytes AA,BB,CC then flush (no in_valid) → out_data=56'hAABBCC00000000, out_count=3, out_partial=1. A second flush with cnt=0 → no output.
5. Bytes AA,BB,CC, then DD with flush asserted in the same cycle → out_data=56'hAABBCCDD000000, out_count=4. Seven bytes with flush on the 7th → out_count=7, out_partial=0.
6. 4 bytes accepted with oreg full, then assert reset for 1 cycle → out_valid=0, all outputs 0, in_ready=1. The next 7 bytes 21..27 produce a clean word 56'h21222324252627.
